// File: rtl/accum_readback_scanner_if.sv
// Bundle of the scanner's control, RAM read and result handshake signals.
// The scanner uses the slave modport; its controller or RAM side uses master.
interface accum_readback_scanner_if #(
    parameter int H_PIXELS          = 320,
    parameter int V_LINES           = 180,
    parameter int LED_ADDRESS_WIDTH = 10
);
    localparam int ADDR_W = $clog2(H_PIXELS * V_LINES);
    localparam int XW     = $clog2(H_PIXELS);
    localparam int YW     = $clog2(V_LINES);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int SX_W   = ADDR_W + XW;
    localparam int SY_W   = ADDR_W + YW;

    logic                         start;
    logic [LED_ADDRESS_WIDTH-1:0] target_id;
    logic                         busy;
    logic                         req_valid_out;
    logic [ADDR_W-1:0]            req_addr_out;
    logic                         rd_valid_in;
    logic [LED_ADDRESS_WIDTH-1:0] rd_data_in;
    logic                         result_valid;
    logic                         result_ready;
    logic                         result_found;
    logic [CNT_W-1:0]             result_count;
    logic [SX_W-1:0]              result_sum_x;
    logic [SY_W-1:0]              result_sum_y;

    modport slave (
        input  start, target_id, rd_valid_in, rd_data_in, result_ready,
        output busy, req_valid_out, req_addr_out, result_valid,
               result_found, result_count, result_sum_x, result_sum_y
    );

    modport master (
        output start, target_id, rd_valid_in, rd_data_in, result_ready,
        input  busy, req_valid_out, req_addr_out, result_valid,
               result_found, result_count, result_sum_x, result_sum_y
    );
endinterface

// File: rtl/accum_readback_scanner.sv
// Raster scan of the downsampled accumulator RAM: counts pixels holding a target
// LED id and sums their x/y coordinates for centroid computation downstream.
//
// state | meaning
// IDLE  | waiting for a rising edge on start
// SCAN  | issuing one READ per cycle, addresses 0..H*V-1
// DRAIN | all requests issued, waiting for the remaining returns
// DONE  | result fields valid, held until result_ready
module accum_readback_scanner #(
    parameter int H_PIXELS          = 320,
    parameter int V_LINES           = 180,
    parameter int LED_ADDRESS_WIDTH = 10
) (
    input  logic                    clk_pixel,
    input  logic                    rst_n,
    accum_readback_scanner_if.slave scan_bus
);
    localparam int ADDR_W = $clog2(H_PIXELS * V_LINES);
    localparam int XW     = $clog2(H_PIXELS);
    localparam int YW     = $clog2(V_LINES);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int SX_W   = ADDR_W + XW;
    localparam int SY_W   = ADDR_W + YW;
    localparam int TOTAL  = H_PIXELS * V_LINES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);
    localparam logic [XW-1:0]     LAST_X    = XW'(H_PIXELS - 1);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;
    logic                         r_start_d;
    logic [LED_ADDRESS_WIDTH-1:0] r_target;
    logic [ADDR_W-1:0]            r_addr;
    logic [CNT_W-1:0]             r_ret_cnt;
    logic [XW-1:0]                r_x;
    logic [YW-1:0]                r_y;
    logic [CNT_W-1:0]             r_count;
    logic [SX_W-1:0]              r_sum_x;
    logic [SY_W-1:0]              r_sum_y;

    logic w_start_edge;
    logic w_accept;
    logic w_ret_take;
    logic w_match;

    assign w_start_edge = scan_bus.start & ~r_start_d;
    assign w_accept     = (r_state == S_IDLE) && w_start_edge;
    // Returns only count while scanning; the RAM is shared, so strays elsewhere are not ours.
    assign w_ret_take   = scan_bus.rd_valid_in
                          && ((r_state == S_SCAN) || (r_state == S_DRAIN))
                          && (r_ret_cnt != TOTAL_CNT);
    assign w_match      = w_ret_take && (scan_bus.rd_data_in == r_target);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_edge) w_state_nxt = S_SCAN;
            S_SCAN:  if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_ret_cnt == TOTAL_CNT) w_state_nxt = S_DONE;
            S_DONE:  if (scan_bus.result_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= scan_bus.start;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= '0;
        end else if ((r_state == S_SCAN) && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Return side tracks raster position with its own x/y counters instead of dividing addresses.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_target  <= '0;
            r_ret_cnt <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_count   <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
        end else if (w_accept) begin
            r_target  <= scan_bus.target_id;
            r_ret_cnt <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_count   <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
        end else if (w_ret_take) begin
            r_ret_cnt <= r_ret_cnt + 1'b1;
            if (r_x == LAST_X) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
            if (w_match) begin
                r_count <= r_count + 1'b1;
                r_sum_x <= r_sum_x + {{ADDR_W{1'b0}}, r_x};
                r_sum_y <= r_sum_y + {{ADDR_W{1'b0}}, r_y};
            end
        end
    end

    assign scan_bus.busy          = (r_state != S_IDLE);
    assign scan_bus.req_valid_out = (r_state == S_SCAN);
    assign scan_bus.req_addr_out  = r_addr;
    assign scan_bus.result_valid  = (r_state == S_DONE);
    assign scan_bus.result_found  = (r_count != '0);
    assign scan_bus.result_count  = r_count;
    assign scan_bus.result_sum_x  = r_sum_x;
    assign scan_bus.result_sum_y  = r_sum_y;
endmodule

// File: tb/tb_accum_readback_scanner.sv
// Bench for accum_readback_scanner on an 8x4 buffer with a variable-latency RAM
// model; expected results come from a direct count over the RAM contents.
module tb_accum_readback_scanner;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LW = 10;
    localparam int N  = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_readback_scanner_if #(.H_PIXELS(H), .V_LINES(V), .LED_ADDRESS_WIDTH(LW)) sbus ();

    accum_readback_scanner #(.H_PIXELS(H), .V_LINES(V), .LED_ADDRESS_WIDTH(LW)) dut (
        .clk_pixel (clk),
        .rst_n     (rst_n),
        .scan_bus  (sbus.slave)
    );

    int checks = 0;
    int errors = 0;

    // RAM model: delay line of requests, read out at stage lat-1.
    logic [LW-1:0] mem [N];
    int            lat = 2;
    bit            pv [8];
    bit [4:0]      pa [8];
    bit            inj_v = 1'b0;
    logic [LW-1:0] inj_d = '0;

    always @(posedge clk) begin
        pv[0] <= sbus.req_valid_out;
        pa[0] <= sbus.req_addr_out;
        for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign sbus.rd_valid_in = pv[lat-1] | inj_v;
    assign sbus.rd_data_in  = inj_v ? inj_d : mem[pa[lat-1]];

    int         cyc = 0;
    logic [4:0] rq_addr [$];
    int         rq_cyc  [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sbus.req_valid_out) begin
            rq_addr.push_back(sbus.req_addr_out);
            rq_cyc.push_back(cyc);
        end
    end

    function automatic void model(input logic [LW-1:0] tgt, output int c, output int sx, output int sy);
        c = 0; sx = 0; sy = 0;
        for (int a = 0; a < N; a++) begin
            if (mem[a] == tgt) begin
                c++;
                sx += a % H;
                sy += a / H;
            end
        end
    endfunction

    task automatic fill(input logic [LW-1:0] v);
        for (int a = 0; a < N; a++) mem[a] = v;
    endtask

    task automatic fill_multi();
        fill('0);
        mem[0] = 10'd7; mem[7] = 10'd7; mem[31] = 10'd7;
    endtask

    task automatic run_scan(input string name, input logic [LW-1:0] tgt, input int latency, input bit hold);
        int ec, esx, esy, n;
        bit bad;
        repeat (8) @(negedge clk);
        lat = latency;
        model(tgt, ec, esx, esy);
        rq_addr.delete();
        rq_cyc.delete();
        sbus.target_id = tgt;
        sbus.start = 1'b1;
        @(negedge clk);
        if (!hold) sbus.start = 1'b0;
        sbus.target_id = tgt ^ 10'h3ff;
        checks++;
        if (sbus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, sbus.busy);
        end
        n = 0;
        while (sbus.result_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbus.result_valid !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout: result_valid got %b want 1", name, sbus.result_valid);
        end
        checks++;
        if (sbus.result_found !== (ec != 0)) begin
            errors++; $display("FAIL %s found: got %b want %0d", name, sbus.result_found, ec != 0);
        end
        checks++;
        if (sbus.result_count !== 6'(ec)) begin
            errors++; $display("FAIL %s count: got %0d want %0d", name, sbus.result_count, ec);
        end
        checks++;
        if (sbus.result_sum_x !== 8'(esx)) begin
            errors++; $display("FAIL %s sum_x: got %0d want %0d", name, sbus.result_sum_x, esx);
        end
        checks++;
        if (sbus.result_sum_y !== 7'(esy)) begin
            errors++; $display("FAIL %s sum_y: got %0d want %0d", name, sbus.result_sum_y, esy);
        end
        bad = (rq_addr.size() != N);
        for (int i = 0; i < rq_addr.size(); i++) begin
            if (rq_addr[i] !== 5'(i) || rq_cyc[i] != rq_cyc[0] + i) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL %s request_stream: got %0d requests want %0d gapless 0..%0d", name, rq_addr.size(), N, N - 1);
        end
        sbus.result_ready = 1'b1;
        @(negedge clk);
        sbus.result_ready = 1'b0;
        checks++;
        if (sbus.result_valid !== 1'b0 || sbus.busy !== 1'b0) begin
            errors++; $display("FAIL %s accept: valid/busy got %b%b want 00", name, sbus.result_valid, sbus.busy);
        end
        checks++;
        if (sbus.result_count !== 6'(ec)) begin
            errors++; $display("FAIL %s hold_after_accept: count got %0d want %0d", name, sbus.result_count, ec);
        end
        if (hold) begin
            repeat (6) @(negedge clk);
            checks++;
            if (sbus.busy !== 1'b0 || rq_addr.size() != N) begin
                errors++; $display("FAIL %s held_start_rescan: busy got %b requests %0d want 0 and %0d", name, sbus.busy, rq_addr.size(), N);
            end
            sbus.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sbus.busy, sbus.req_valid_out, sbus.result_valid, sbus.result_found} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000",
                {sbus.busy, sbus.req_valid_out, sbus.result_valid, sbus.result_found});
        end
        checks++;
        if (sbus.req_addr_out !== '0 || sbus.result_count !== '0 || sbus.result_sum_x !== '0 || sbus.result_sum_y !== '0) begin
            errors++; $display("FAIL reset_fields: addr %0d count %0d sx %0d sy %0d want all 0",
                sbus.req_addr_out, sbus.result_count, sbus.result_sum_x, sbus.result_sum_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        fill('0);
        mem[19] = 10'd5;
        run_scan("single", 10'd5, 2, 1'b0);
    endtask

    task automatic test_multi();
        fill_multi();
        run_scan("multi", 10'd7, 2, 1'b0);
    endtask

    task automatic test_no_match();
        fill('0);
        run_scan("no_match", 10'd9, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < N; a++) mem[a] = 10'($urandom_range(0, 3));
            run_scan("random", 10'($urandom_range(0, 3)), $urandom_range(1, 5), 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int ec, esx, esy, n;
        logic [LW-1:0] tgt;
        for (int a = 0; a < N; a++) mem[a] = 10'($urandom_range(0, 2));
        tgt = 10'd1;
        model(tgt, ec, esx, esy);
        repeat (8) @(negedge clk);
        lat = 3;
        rq_addr.delete();
        sbus.target_id = tgt;
        sbus.start = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        n = 0;
        while (sbus.result_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            sbus.start = (c == 3);
            inj_v = (c == 5 || c == 6);
            inj_d = tgt;
            @(negedge clk);
            checks++;
            if (sbus.result_valid !== 1'b1 || sbus.result_count !== 6'(ec)
                || sbus.result_sum_x !== 8'(esx) || sbus.result_sum_y !== 7'(esy)) begin
                errors++; $display("FAIL backpressure_hold c%0d: valid %b count %0d sx %0d sy %0d want 1 %0d %0d %0d",
                    c, sbus.result_valid, sbus.result_count, sbus.result_sum_x, sbus.result_sum_y, ec, esx, esy);
            end
        end
        inj_v = 1'b0;
        sbus.start = 1'b0;
        sbus.result_ready = 1'b1;
        @(negedge clk);
        sbus.result_ready = 1'b0;
        checks++;
        if (sbus.result_valid !== 1'b0 || sbus.busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: valid/busy got %b%b want 00", sbus.result_valid, sbus.busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sbus.busy !== 1'b0 || rq_addr.size() != N) begin
            errors++; $display("FAIL backpressure_ignored_start: busy %b requests %0d want 0 and %0d", sbus.busy, rq_addr.size(), N);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        fill_multi();
        repeat (8) @(negedge clk);
        lat = 5;
        sbus.target_id = 10'd7;
        sbus.start = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        n = 0;
        while (sbus.req_addr_out !== 5'd12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbus.req_addr_out !== 5'd12) begin
            errors++; $display("FAIL mid_reset_reach_addr12: got %0d want 12", sbus.req_addr_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sbus.busy, sbus.req_valid_out, sbus.result_valid, sbus.result_found} !== 4'b0
            || sbus.req_addr_out !== '0 || sbus.result_count !== '0) begin
            errors++; $display("FAIL mid_reset_async: flags %b addr %0d count %0d want 0",
                {sbus.busy, sbus.req_valid_out, sbus.result_valid, sbus.result_found}, sbus.req_addr_out, sbus.result_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (sbus.busy !== 1'b0 || sbus.result_count !== '0 || sbus.result_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_inflight_ignored: busy %b count %0d valid %b want 0 0 0",
                sbus.busy, sbus.result_count, sbus.result_valid);
        end
        run_scan("after_reset", 10'd7, 2, 1'b0);
    endtask

    task automatic test_latency_sweep();
        fill_multi();
        run_scan("lat1", 10'd7, 1, 1'b1);
        run_scan("lat2", 10'd7, 2, 1'b1);
        run_scan("lat5", 10'd7, 5, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        sbus.start        = 1'b0;
        sbus.target_id    = '0;
        sbus.result_ready = 1'b0;
        fill('0);
        test_reset();
        test_single();
        test_multi();
        test_no_match();
        test_backpressure();
        test_reset_mid_scan();
        test_latency_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
